// File: rtl/health_recovery.sv
// Output-path fault recovery: fades the sample stream to silence on a monitor fault,
// holds mute, re-arms the monitor and fades back in; repeated faults latch FAULT until clear.
module health_recovery #(
    parameter int DATA_WIDTH   = 16,
    parameter int GAIN_WIDTH   = 8,
    parameter int FADE_STEP    = 64,
    parameter int HOLD_SAMPLES = 4800,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    input  logic                         health,
    input  logic                         clear,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_out_valid,
    output logic                         monitor_reset,
    output logic                         muted,
    output logic                         fault
);

    localparam int GW1 = GAIN_WIDTH + 1;
    localparam int PW  = DATA_WIDTH + GW1;
    localparam int RW  = $clog2(MAX_RETRIES + 2);
    localparam int HW  = $clog2(HOLD_SAMPLES + 1);

    localparam logic [GW1-1:0] UNITY_G   = GW1'(1 << GAIN_WIDTH);
    localparam logic [GW1-1:0] STEP_G    = GW1'(FADE_STEP);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [RW-1:0]  RETRY_SAT = RW'(MAX_RETRIES + 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_SAMPLES - 1);

    // state    | meaning
    // S_RUN    | unity gain, watching health and the clean-sample window
    // S_FADE_OUT | ramping gain down one step per valid sample
    // S_HOLD   | muted, counting samples before a re-arm attempt
    // S_FADE_IN  | ramping gain up to unity
    // S_FAULT  | sticky mute until the host clears
    typedef enum logic [2:0] {
        S_RUN,
        S_FADE_OUT,
        S_HOLD,
        S_FADE_IN,
        S_FAULT
    } state_t;

    state_t          state, state_n;
    logic [GW1-1:0]  gain, gain_n, gain_dn, gain_up, gain_mul;
    logic [GW1:0]    gain_sum;
    logic [RW-1:0]   retry_ctr, retry_n, retry_inc;
    logic [HW-1:0]   hold_ctr, hold_n;
    logic            mr_n;
    logic            trip;
    logic            v1;
    logic signed [PW-1:0] prod_q, a_ext, g_ext;

    assign gain_dn   = (gain > STEP_G) ? gain - STEP_G : '0;
    assign gain_sum  = {1'b0, gain} + {1'b0, STEP_G};
    assign gain_up   = (gain_sum >= {1'b0, UNITY_G}) ? UNITY_G : gain_sum[GW1-1:0];
    assign retry_inc = (retry_ctr >= RETRY_SAT) ? retry_ctr : retry_ctr + RW'(1);
    assign trip      = (retry_ctr >= RETRY_MAX);

    always_comb begin
        state_n = state;
        gain_n  = gain;
        retry_n = retry_ctr;
        hold_n  = hold_ctr;
        mr_n    = 1'b0;
        if (enable) begin
            case (state)
                S_RUN: begin
                    if (!health) begin
                        retry_n = retry_inc;
                        if (trip) begin
                            state_n = S_FAULT;
                            gain_n  = '0;
                        end else begin
                            state_n = S_FADE_OUT;
                        end
                    end else if (sample_valid) begin
                        if (hold_ctr >= HOLD_LAST) begin
                            retry_n = '0;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_ctr + HW'(1);
                        end
                    end
                end
                S_FADE_OUT: begin
                    if (sample_valid) begin
                        gain_n = gain_dn;
                        if (gain_dn == '0) begin
                            state_n = S_HOLD;
                            hold_n  = '0;
                            mr_n    = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    gain_n = '0;
                    if (sample_valid) begin
                        if (hold_ctr >= HOLD_LAST) begin
                            hold_n = '0;
                            if (health) begin
                                state_n = S_FADE_IN;
                            end else begin
                                mr_n = 1'b1;
                            end
                        end else begin
                            hold_n = hold_ctr + HW'(1);
                        end
                    end
                end
                S_FADE_IN: begin
                    if (!health) begin
                        retry_n = retry_inc;
                        if (trip) begin
                            state_n = S_FAULT;
                            gain_n  = '0;
                        end else begin
                            state_n = S_FADE_OUT;
                        end
                    end else if (sample_valid) begin
                        gain_n = gain_up;
                        if (gain_up == UNITY_G) begin
                            state_n = S_RUN;
                            hold_n  = '0;
                        end
                    end
                end
                S_FAULT: begin
                    gain_n = '0;
                    if (clear) begin
                        state_n = S_FADE_IN;
                        retry_n = '0;
                        mr_n    = 1'b1;
                    end
                end
                default: begin
                    state_n = S_RUN;
                    gain_n  = UNITY_G;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_RUN;
            gain          <= UNITY_G;
            retry_ctr     <= '0;
            hold_ctr      <= '0;
            monitor_reset <= 1'b0;
        end else begin
            state         <= state_n;
            gain          <= gain_n;
            retry_ctr     <= retry_n;
            hold_ctr      <= hold_n;
            monitor_reset <= mr_n;
        end
    end

    // Entering FAULT silences the sample that triggered it, not just the ones after.
    assign gain_mul = (state_n == S_FAULT) ? '0 : gain;
    assign a_ext    = PW'(sample_in);
    assign g_ext    = $signed(PW'({1'b0, gain_mul}));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1               <= 1'b0;
            prod_q           <= '0;
            sample_out_valid <= 1'b0;
            sample_out       <= '0;
        end else begin
            v1               <= sample_valid;
            sample_out_valid <= v1;
            if (sample_valid) begin
                prod_q <= a_ext * g_ext;
            end
            if (v1) begin
                sample_out <= DATA_WIDTH'(prod_q >>> GAIN_WIDTH);
            end
        end
    end

    assign muted = (gain == '0);
    assign fault = (state == S_FAULT);

endmodule

// File: tb/tb_health_recovery.sv
// Scoreboard bench for health_recovery: expected samples are queued at drive time
// and compared as sample_out_valid arrives; control outputs are checked inline per test.
module tb_health_recovery;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 sample_valid = 1'b0;
    logic signed [DW-1:0] sample_in = '0;
    logic                 health = 1'b1;
    logic                 clear = 1'b0;
    logic signed [DW-1:0] sample_out;
    logic                 sample_out_valid;
    logic                 monitor_reset;
    logic                 muted;
    logic                 fault;

    int total = 0;
    int bad = 0;
    int mr_cnt = 0;
    logic signed [DW-1:0] exp_q[$];

    health_recovery #(
        .DATA_WIDTH(16), .GAIN_WIDTH(8), .FADE_STEP(64), .HOLD_SAMPLES(8), .MAX_RETRIES(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
        .sample_in(sample_in), .health(health), .clear(clear), .sample_out(sample_out),
        .sample_out_valid(sample_out_valid), .monitor_reset(monitor_reset),
        .muted(muted), .fault(fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && sample_out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_sample: got %0d, none expected", sample_out);
            end else begin
                logic signed [DW-1:0] e;
                e = exp_q.pop_front();
                if (sample_out !== e) begin
                    bad++;
                    $display("FAIL sample_out: got %0d expected %0d", sample_out, e);
                end
            end
        end
        if (reset_n && monitor_reset) mr_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic signed [DW-1:0] v, input logic h, input logic signed [DW-1:0] e);
        sample_valid = 1'b1;
        sample_in    = v;
        health       = h;
        clear        = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic sendn(input int n, input logic signed [DW-1:0] v, input logic h,
                         input logic signed [DW-1:0] e);
        for (int i = 0; i < n; i++) send(v, h, e);
    endtask

    task automatic idle(input logic h, input logic c);
        sample_valid = 1'b0;
        health       = h;
        clear        = c;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic drain();
        sample_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        enable = 1'b0; sample_valid = 1'b0; health = 1'b1; clear = 1'b0;
        #12;
        reset_n = 1'b1;
        @(posedge clk); #1;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (sample_out !== 16'sd0) begin bad++; $display("FAIL rst_sample_out: got %0d expected 0", sample_out); end
        total++; if (sample_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", sample_out_valid); end
        total++; if (monitor_reset !== 1'b0) begin bad++; $display("FAIL rst_monitor_reset: got %b expected 0", monitor_reset); end
        total++; if (muted !== 1'b0) begin bad++; $display("FAIL rst_muted: got %b expected 0", muted); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b expected 0", fault); end
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        enable = 1'b1;
    endtask

    task automatic test_passthrough();
        int mr0;
        mr0 = mr_cnt;
        send(16'sd1000, 1'b1, 16'sd1000);
        send(-16'sd1000, 1'b1, -16'sd1000);
        send(16'sd32767, 1'b1, 16'sd32767);
        idle(1'b1, 1'b1);
        drain();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pass_drain: got %0d pending expected 0", exp_q.size()); end
        total++; if (muted !== 1'b0) begin bad++; $display("FAIL pass_muted: got %b expected 0", muted); end
        total++; if (mr_cnt - mr0 != 0) begin bad++; $display("FAIL pass_clear_ignored: got %0d pulses expected 0", mr_cnt - mr0); end
    endtask

    task automatic test_fade_out();
        int mr0;
        mr0 = mr_cnt;
        send(16'sd1000, 1'b0, 16'sd1000);
        send(16'sd1000, 1'b0, 16'sd1000);
        send(16'sd1000, 1'b0, 16'sd750);
        send(16'sd1000, 1'b0, 16'sd500);
        send(16'sd1000, 1'b0, 16'sd250);
        drain();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL fade_drain: got %0d pending expected 0", exp_q.size()); end
        total++; if (mr_cnt - mr0 != 1) begin bad++; $display("FAIL fade_mon_pulse: got %0d expected 1", mr_cnt - mr0); end
        total++; if (muted !== 1'b1) begin bad++; $display("FAIL fade_muted: got %b expected 1", muted); end
    endtask

    task automatic test_hold_recover();
        int mr0;
        mr0 = mr_cnt;
        sendn(8, 16'sd1000, 1'b1, 16'sd0);
        send(16'sd1000, 1'b1, 16'sd0);
        send(16'sd1000, 1'b1, 16'sd250);
        send(16'sd1000, 1'b1, 16'sd500);
        send(16'sd1000, 1'b1, 16'sd750);
        sendn(2, 16'sd1000, 1'b1, 16'sd1000);
        drain();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL hold_drain: got %0d pending expected 0", exp_q.size()); end
        total++; if (muted !== 1'b0) begin bad++; $display("FAIL hold_muted: got %b expected 0", muted); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL hold_fault: got %b expected 0", fault); end
        total++; if (mr_cnt - mr0 != 0) begin bad++; $display("FAIL hold_mon_pulse: got %0d expected 0", mr_cnt - mr0); end
    endtask

    task automatic test_retry_fault();
        int mr0;
        do_reset();
        mr0 = mr_cnt;
        idle(1'b0, 1'b0);
        send(16'sd1000, 1'b1, 16'sd1000);
        send(16'sd1000, 1'b1, 16'sd750);
        send(16'sd1000, 1'b1, 16'sd500);
        send(16'sd1000, 1'b1, 16'sd250);
        sendn(8, 16'sd1000, 1'b0, 16'sd0);
        sendn(8, 16'sd1000, 1'b1, 16'sd0);
        send(16'sd1000, 1'b1, 16'sd0);
        for (int r = 0; r < 2; r++) begin
            idle(1'b0, 1'b0);
            send(16'sd1000, 1'b1, 16'sd250);
            sendn(8, 16'sd1000, 1'b1, 16'sd0);
            send(16'sd1000, 1'b1, 16'sd0);
        end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL retry_early_fault: got %b expected 0", fault); end
        send(16'sd1000, 1'b0, 16'sd0);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL retry_fault_set: got %b expected 1", fault); end
        total++; if (muted !== 1'b1) begin bad++; $display("FAIL retry_fault_muted: got %b expected 1", muted); end
        send(16'sd1000, 1'b1, 16'sd0);
        send(-16'sd5, 1'b0, 16'sd0);
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL retry_sticky: got %b expected 1", fault); end
        idle(1'b0, 1'b1);
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL retry_clear: got %b expected 0", fault); end
        send(16'sd1000, 1'b1, 16'sd0);
        send(16'sd1000, 1'b1, 16'sd250);
        send(16'sd1000, 1'b1, 16'sd500);
        send(16'sd1000, 1'b1, 16'sd750);
        send(16'sd1000, 1'b1, 16'sd1000);
        drain();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL retry_drain: got %0d pending expected 0", exp_q.size()); end
        total++; if (mr_cnt - mr0 != 5) begin bad++; $display("FAIL retry_mon_pulses: got %0d expected 5", mr_cnt - mr0); end
        total++; if (muted !== 1'b0) begin bad++; $display("FAIL retry_muted: got %b expected 0", muted); end
    endtask

    task automatic test_rounding();
        do_reset();
        idle(1'b0, 1'b0);
        send(16'sd1000, 1'b1, 16'sd1000);
        send(16'sd1000, 1'b1, 16'sd750);
        enable = 1'b0;
        send(-16'sd32768, 1'b1, -16'sd16384);
        send(-16'sd1, 1'b1, -16'sd1);
        send(16'sd1, 1'b1, 16'sd0);
        send(16'sd32767, 1'b1, 16'sd16383);
        send(-16'sd32768, 1'b0, -16'sd16384);
        drain();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL round_drain: got %0d pending expected 0", exp_q.size()); end
        total++; if (muted !== 1'b0) begin bad++; $display("FAIL round_muted: got %b expected 0", muted); end
    endtask

    task automatic test_reset_mid_fade();
        enable       = 1'b1;
        health       = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'sd1000;
        exp_q.push_back(16'sd500);
        @(posedge clk); #1;
        exp_q.push_back(16'sd250);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (sample_out !== 16'sd500) begin bad++; $display("FAIL mid_pre_reset: got %0d expected 500", sample_out); end
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        total++; if (sample_out !== 16'sd0) begin bad++; $display("FAIL mid_async_out: got %0d expected 0", sample_out); end
        total++; if (sample_out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b expected 0", sample_out_valid); end
        total++; if (muted !== 1'b0) begin bad++; $display("FAIL mid_async_muted: got %b expected 0", muted); end
        #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL mid_fault: got %b expected 0", fault); end
        send(16'sd1000, 1'b1, 16'sd1000);
        send(-16'sd32768, 1'b1, -16'sd32768);
        drain();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_fade_out();
        test_hold_recover();
        test_retry_fault();
        test_rounding();
        test_reset_mid_fade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
